// File: rtl/wide_add_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the wide-operand adder sequencer: the controller
// state encoding, the chunk width and the chunk index width.
// No ports (package).
// ---------------------------------------------------------------------------
package wide_add_pkg;

  // Every operand is processed in chunks of this many bits
  localparam int CHUNK_W = 16;

  // Index width is sized for the largest legal WORDS (16) so that every
  // configuration shares one index width
  localparam int IDX_W = $clog2(16);

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_select_adder_16bit.sv
// ---------------------------------------------------------------------------
// carry_select_adder_16bit
// Purely combinational 16-bit adder. The low byte ripples directly; the high
// byte is computed twice (carry-in 0 and carry-in 1) and the low byte's
// carry-out picks the correct copy.
// Ports:
//   a, b  : 16-bit addends
//   cin   : carry into bit 0
//   sum   : 16-bit sum
//   cout  : carry out of bit 15
// ---------------------------------------------------------------------------
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [7:0] w_sumLo;
  logic       w_carryLo;
  logic [7:0] w_sumHi0;
  logic       w_carryHi0;
  logic [7:0] w_sumHi1;
  logic       w_carryHi1;

  // Low byte: straightforward ripple add including the external carry
  assign {w_carryLo, w_sumLo} = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, cin};

  // High byte: both candidate results computed in parallel
  assign {w_carryHi0, w_sumHi0} = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign {w_carryHi1, w_sumHi1} = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  // The low byte's carry selects which high-byte candidate is real
  assign sum  = {(w_carryLo ? w_sumHi1 : w_sumHi0), w_sumLo};
  assign cout = w_carryLo ? w_carryHi1 : w_carryHi0;

endmodule

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
// Adds two 16*WORDS-bit operands by time-sharing a single 16-bit
// carry_select_adder_16bit: one chunk per cycle, least-significant first,
// with the inter-chunk carry held in a register. Valid/ready handshakes on
// both the operand and result sides.
// Parameters:
//   WORDS     : number of 16-bit chunks per operand (2..16)
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a, b, cin are valid
//   in_ready  : block accepts operands (IDLE only)
//   a, b      : 16*WORDS-bit operands
//   cin       : carry into chunk 0
//   out_valid : sum and cout are valid (DONE only)
//   out_ready : consumer takes the result
//   sum       : (a + b + cin) mod 2^(16*WORDS), registered
//   cout      : carry out of the top chunk, registered
//   busy      : state is not IDLE
// ---------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHUNK_W*WORDS-1:0] a,
  input  logic [CHUNK_W*WORDS-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHUNK_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int               WIDTH    = CHUNK_W * WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;

  logic [CHUNK_W-1:0] w_chunkA;
  logic [CHUNK_W-1:0] w_chunkB;
  logic [CHUNK_W-1:0] w_chunkSum;
  logic               w_chunkCout;

  // The shared adder always sees the chunk selected by the current index and
  // the registered carry; its result is only captured while in RUN
  assign w_chunkA = r_opA[r_idx*CHUNK_W +: CHUNK_W];
  assign w_chunkB = r_opB[r_idx*CHUNK_W +: CHUNK_W];

  carry_select_adder_16bit u_adder (
    .a    (w_chunkA),
    .b    (w_chunkB),
    .cin  (r_carry),
    .sum  (w_chunkSum),
    .cout (w_chunkCout)
  );

  // State register; reset returns to IDLE from anywhere, discarding any
  // operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. The handshake outputs depend only on
  // the registered state, so there is no combinational path from inputs.
  // in_valid outside IDLE and out_ready outside DONE are simply ignored.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. Operands are copied only on the accepting edge so later input
  // changes cannot disturb the operation. The carry register is seeded with
  // cin so that chunk 0 sees it, then carries each chunk's cout forward.
  // The result register is cleared by reset so a discarded result never
  // lingers on sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= a;
            r_opB   <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx*CHUNK_W +: CHUNK_W] <= w_chunkSum;
          r_carry                         <= w_chunkCout;
          r_idx                           <= r_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // After the last chunk the carry register holds the top chunk's carry-out
  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_add_sequencer
// Directed, self-checking bench for wide_add_sequencer with WORDS=4.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         cin;
    logic [63:0]  expSum;
    logic         expCout;
  } vec_t;

  vec_t vecs[6];

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present operands on a falling edge and hold in_valid across one rising
  // edge (the accept edge); returns just after that edge
  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                               input logic ci);
    @(negedge clk);
    a        = av;
    b        = bv;
    cin      = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges after acceptance until out_valid is seen; bounded.
  // Returns sitting on a falling edge.
  task automatic waitResult(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  // Pulse out_ready for one edge and confirm the block is back in IDLE
  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, ".out_valid_after"}, 64'(out_valid), 64'd0);
    checkOutput({name, ".in_ready_after"},  64'(in_ready),  64'd1);
    checkOutput({name, ".busy_after"},      64'(busy),      64'd0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{"small_add",   64'd2, 64'd2, 1'b1, 64'd5, 1'b0};
    vecs[1] = '{"cross_chunk", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                64'h0000_0000_0001_0000, 1'b0};
    vecs[2] = '{"full_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                64'd0, 1'b1};
    vecs[3] = '{"top_overflow", 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    vecs[4] = '{"no_carry",    64'h1234_5678_9ABC_DEF0,
                64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0};
    vecs[5] = '{"split_carry", 64'hFFFF_0000_FFFF_0000,
                64'h0001_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset.in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset.busy",      64'(busy),      64'd0);
    checkOutput("reset.sum",       sum,            64'd0);
    checkOutput("reset.cout",      64'(cout),      64'd0);

    // Table-driven arithmetic and latency
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      waitResult(lat);
      checkOutput({vecs[i].name, ".latency"},  64'(lat),      64'd4);
      checkOutput({vecs[i].name, ".sum"},      sum,           vecs[i].expSum);
      checkOutput({vecs[i].name, ".cout"},     64'(cout),     64'(vecs[i].expCout));
      checkOutput({vecs[i].name, ".in_ready"}, 64'(in_ready), 64'd0);
      checkOutput({vecs[i].name, ".busy"},     64'(busy),     64'd1);
      releaseResult(vecs[i].name);
    end

    // Backpressure: result held for three cycles while out_ready stays low
    applyStimulus(64'd100, 64'd0, 1'b0);
    waitResult(lat);
    checkOutput("bp.latency", 64'(lat), 64'd4);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp.out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp.sum",       sum,            64'd100);
      checkOutput("bp.in_ready",  64'(in_ready),  64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    releaseResult("bp");

    // Input isolation: operands scribbled and a second in_valid during RUN
    applyStimulus(64'd12, 64'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      a        = 64'hFFFF;
      b        = 64'd7;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("iso.out_valid", 64'(out_valid), 64'd1);
    checkOutput("iso.sum",       sum,            64'd16);
    checkOutput("iso.cout",      64'(cout),      64'd0);
    releaseResult("iso");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("iso.no_second_busy",  64'(busy),      64'd0);
      checkOutput("iso.no_second_valid", 64'(out_valid), 64'd0);
    end

    // Reset on the second RUN cycle discards the partial result
    applyStimulus(64'd5, 64'd6, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstrun.busy",      64'(busy),      64'd0);
    checkOutput("rstrun.out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstrun.sum",       sum,            64'd0);
    checkOutput("rstrun.in_ready",  64'(in_ready),  64'd1);
    applyStimulus(64'd2, 64'd4, 1'b1);
    waitResult(lat);
    checkOutput("rstrun.next_latency", 64'(lat),  64'd4);
    checkOutput("rstrun.next_sum",     sum,       64'd7);
    checkOutput("rstrun.next_cout",    64'(cout), 64'd0);
    releaseResult("rstrun.next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide-operand adder controller that time-shares one `carry_select_adder_16bit` instance to add two `16*WORDS`-bit operands. It processes one 16-bit chunk per cycle, least-significant chunk first, and chains the carry between chunks in a register. A valid/ready handshake is used on both the operand side and the result side. It sits between operand producers (accumulators, address generators) and consumers that need wider-than-16-bit sums without a wide combinational carry chain.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit chunks per operand; legal range 2..16.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: operands `a`, `b` and `cin` are valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, 16*WORDS: operand A.
- `b`, input, 16*WORDS: operand B.
- `cin`, input, 1: carry into chunk 0.
- `out_valid`, output, 1: `sum` and `cout` are valid.
- `out_ready`, input, 1: consumer takes the result.
- `sum`, output, 16*WORDS: `(a + b + cin) mod 2^(16*WORDS)`.
- `cout`, output, 1: carry out of the top chunk.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid` is high, latch `a`, `b` and `cin` into internal registers.
  - Clear the chunk index to 0, then go to RUN.
- **RUN:** in each cycle:
  - Drive the adder with chunk `idx` of the latched A and B, and with the carry register. The carry register holds latched `cin` when `idx`=0.
  - Write the adder sum into chunk `idx` of the result register.
  - Load the adder cout into the carry register.
  - Increment `idx`.
  - When the last chunk is done (`idx`=WORDS-1), go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `sum` and `cout` stay stable until `out_ready` is high.
  - On `out_ready`, go to IDLE.
  - New operands are not accepted in the same cycle as `out_ready`; `in_ready` is 0 in DONE.
- Operand inputs are sampled only on the accepting edge. Later changes on `a`, `b` or `cin` have no effect on the operation in flight.
- Arithmetic:
  - Every chunk is exactly 16 bits.
  - Carry propagates only through the registered carry.
  - Overflow wraps modulo `2^(16*WORDS)`, with `cout` reporting the carry.
- `in_valid` seen in RUN or DONE is ignored, not queued. The producer holds its operands until it sees `in_ready`.
- `out_ready` seen outside DONE is ignored.

## Timing
- **Reset values:**
  - State is IDLE and `idx`=0.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `sum`=0, `cout`=0, and the carry register is 0.
- **Reset mid-operation:**
  - A reset during RUN or DONE returns the block to IDLE on that edge.
  - The result is discarded, and `out_valid` is 0 the next cycle.
- **Latency:**
  - The accept edge is edge 0.
  - RUN occupies edges 1..WORDS.
  - `out_valid` rises after edge WORDS, i.e. WORDS cycles after acceptance.
- **Throughput:** at most one operation per WORDS+2 cycles: accept, WORDS RUN cycles, and a minimum of one DONE cycle.
- **Result outputs:**
  - `sum` and `cout` are registered outputs.
  - Intermediate chunk writes are visible on `sum` during RUN but are undefined to consumers.
  - Only `out_valid` qualifies them.
- `in_ready`, `out_valid` and `busy` are decoded from registered state, with no combinational path from inputs.

## Structure
- **Shared package `wide_add_pkg`:**
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `CHUNK_W`=16.
  - Index width: `IDX_W = $clog2(16)`=4. This is fixed so that all WORDS values share one width.
- **Sub-module:**
  - One instance of the existing `carry_select_adder_16bit`, with ports `a`, `b`, `cin`, `sum` and `cout`.
  - Chunk selection uses indexed part-selects, `[idx*16 +: 16]`.

## Test plan
All scenarios use WORDS=4.
- **Small add:** a=2, b=2, cin=1 -> sum=5, cout=0. `out_valid` rises exactly 4 cycles after the accept edge.
- **Cross-chunk carry:** a=64'h0000_0000_0000_FFFF, b=1, cin=0 -> sum=64'h0000_0000_0001_0000, cout=0.
- **Full ripple and wrap:** a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
- **Backpressure:**
  - Run a=100, b=0, cin=0 and hold `out_ready`=0 for 3 cycles in DONE.
  - Required: `out_valid` stays 1 and sum stays 100 throughout; `in_ready` stays 0.
  - When `out_ready` is pulsed, the block returns to IDLE the next cycle.
- **Input isolation:**
  - Accept a=12, b=3, cin=1, then change `a` to 64'hFFFF every cycle during RUN.
  - Required: sum=16, cout=0.
  - A second `in_valid` during RUN is ignored, and exactly one result is produced.
- **Reset mid-RUN:**
  - Assert `rst` on the second RUN cycle.
  - Required: next cycle has state IDLE, `out_valid`=0, `sum`=0, `in_ready`=1.
  - A subsequent add of 2+4+1 then gives 7.
